// File: rtl/xt_hb_arbiter_pkg.sv
// Shared types, constants and the round-robin pick helper for the XT_HB arbiter.
package XT_HB_Pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  localparam int HB_ARB_TIMEOUT = 1024;
  localparam int HB_MAX_MASTERS = 8;

  // Returns a one-hot vector selecting the first set bit of req at or after ptr,
  // wrapping modulo n. Vectors are sized for the largest legal master count and
  // bits at or above n are never selected.
  function automatic logic [7:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int unsigned n);
    logic [7:0]  grant;
    logic        found;
    int unsigned idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !found && req[idx[2:0]]) begin
        grant[idx[2:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/xt_hb_rr_channel.sv
// One arbitration channel: round-robin pointer, IDLE/BUSY FSM, grant register
// and the per-transaction timeout counter. Instantiated once for reads and once
// for writes.
module xt_hb_rr_channel
  import XT_HB_Pkg::*;
#(
  parameter  int MASTER_NUM = 2,
  parameter  int TIMEOUT    = HB_ARB_TIMEOUT,
  localparam int IW         = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [MASTER_NUM-1:0] i_req,
  input  logic                  i_finish,
  output logic [MASTER_NUM-1:0] o_grant,
  output logic                  o_timeout,
  output logic [IW-1:0]         o_grantIdx
);

  // Counter is wide enough to hold TIMEOUT so it can saturate instead of wrapping.
  localparam int              CW        = $clog2(TIMEOUT + 2);
  localparam int              TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0]   TO_LAST   = TO_LAST_I[CW-1:0];
  localparam logic [CW-1:0]   CNT_MAX   = {CW{1'b1}};

  arb_state_e            r_state;
  logic [MASTER_NUM-1:0] r_grant;
  logic [IW-1:0]         r_ptr;
  logic [CW-1:0]         r_cnt;

  logic [7:0]    w_reqExt;
  logic [7:0]    w_grantExt;
  logic [2:0]    w_ptrExt;
  logic [2:0]    w_nextPtrExt;
  logic [7:0]    w_pickIdle;
  logic [7:0]    w_pickBusy;
  logic [IW-1:0] w_grantIdx;
  logic [IW-1:0] w_nextPtr;
  logic          w_held;
  logic          w_timeout;
  logic          w_done;

  // Zero-extend to the helper's fixed width and decode the granted index.
  always_comb begin
    w_reqExt                    = '0;
    w_reqExt[MASTER_NUM-1:0]    = i_req;
    w_grantExt                  = '0;
    w_grantExt[MASTER_NUM-1:0]  = r_grant;
    w_ptrExt                    = '0;
    w_ptrExt[IW-1:0]            = r_ptr;
    w_grantIdx                  = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (r_grant[i]) w_grantIdx = IW'(i);
    end
    w_nextPtr                   = (w_grantIdx == IW'(MASTER_NUM - 1)) ? '0 : w_grantIdx + 1'b1;
    w_nextPtrExt                = '0;
    w_nextPtrExt[IW-1:0]        = w_nextPtr;
  end

  // A transaction ends on finish, on the granted master dropping its request,
  // or on timeout; the finishing master is masked out of the immediate re-pick.
  always_comb begin
    w_held     = |(i_req & r_grant);
    w_timeout  = (r_state == ARB_BUSY) && (TIMEOUT != 0) && !i_rst && !i_finish &&
                 w_held && (r_cnt == TO_LAST);
    w_done     = i_finish || !w_held || w_timeout;
    w_pickIdle = rr_pick(w_reqExt, w_ptrExt, MASTER_NUM);
    w_pickBusy = rr_pick(w_reqExt & ~w_grantExt, w_nextPtrExt, MASTER_NUM);
  end

  // Channel FSM with registered grant, pointer and saturating timeout counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (|w_pickIdle) begin
            r_grant <= w_pickIdle[MASTER_NUM-1:0];
            r_cnt   <= '0;
            r_state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (w_done) begin
            r_ptr <= w_nextPtr;
            r_cnt <= '0;
            if (|w_pickBusy) begin
              r_grant <= w_pickBusy[MASTER_NUM-1:0];
            end else begin
              r_grant <= '0;
              r_state <= ARB_IDLE;
            end
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign o_grant    = r_grant;
  assign o_timeout  = w_timeout;
  assign o_grantIdx = w_grantIdx;

endmodule

// File: rtl/xt_hb_arbiter.sv
// XT_HB bus arbiter: independent round-robin read and write channels, per-master
// stall generation and timeout reporting.
module xt_hb_arbiter
  import XT_HB_Pkg::*;
#(
  parameter  int MASTER_NUM = 2,
  parameter  int TIMEOUT    = HB_ARB_TIMEOUT,
  localparam int IDW        = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
  input  logic                  hb_clk,
  input  logic                  rst_sync,
  input  logic [MASTER_NUM-1:0] m_read,
  input  logic [MASTER_NUM-1:0] m_write,
  input  logic                  read_finish,
  input  logic                  write_finish,
  output logic [MASTER_NUM-1:0] read_grant,
  output logic [MASTER_NUM-1:0] write_grant,
  output logic [MASTER_NUM-1:0] stall_req,
  output logic                  read_timeout,
  output logic                  write_timeout,
  output logic [IDW-1:0]        timeout_id
);

  logic [IDW-1:0] w_rdIdx;
  logic [IDW-1:0] w_wrIdx;
  logic           w_rdTo;
  logic           w_wrTo;
  logic [IDW-1:0] r_timeoutId;

  xt_hb_rr_channel #(
    .MASTER_NUM (MASTER_NUM),
    .TIMEOUT    (TIMEOUT)
  ) u_readChannel (
    .i_clk      (hb_clk),
    .i_rst      (rst_sync),
    .i_req      (m_read),
    .i_finish   (read_finish),
    .o_grant    (read_grant),
    .o_timeout  (w_rdTo),
    .o_grantIdx (w_rdIdx)
  );

  xt_hb_rr_channel #(
    .MASTER_NUM (MASTER_NUM),
    .TIMEOUT    (TIMEOUT)
  ) u_writeChannel (
    .i_clk      (hb_clk),
    .i_rst      (rst_sync),
    .i_req      (m_write),
    .i_finish   (write_finish),
    .o_grant    (write_grant),
    .o_timeout  (w_wrTo),
    .o_grantIdx (w_wrIdx)
  );

  // Remember the master of the latest timeout; read wins when both fire together.
  // With a single master both indices are always 0, so this stays tied to 0.
  always_ff @(posedge hb_clk) begin
    if (rst_sync) begin
      r_timeoutId <= '0;
    end else if (w_rdTo) begin
      r_timeoutId <= w_rdIdx;
    end else if (w_wrTo) begin
      r_timeoutId <= w_wrIdx;
    end
  end

  // The timeout index is visible in the pulse cycle itself and held afterwards.
  assign timeout_id    = w_rdTo ? w_rdIdx : (w_wrTo ? w_wrIdx : r_timeoutId);
  assign read_timeout  = w_rdTo;
  assign write_timeout = w_wrTo;

  // A requester stalls until its channel completes: on finish or on timeout release.
  assign stall_req =
      (m_read  & ~(read_grant  & {MASTER_NUM{read_finish  | w_rdTo}})) |
      (m_write & ~(write_grant & {MASTER_NUM{write_finish | w_wrTo}}));

endmodule

// File: tb/tb_xt_hb_arbiter.sv
// Directed testbench for xt_hb_arbiter with two masters and a short timeout.
module tb_xt_hb_arbiter;

  logic       hb_clk;
  logic       rst_sync;
  logic [1:0] m_read;
  logic [1:0] m_write;
  logic       read_finish;
  logic       write_finish;
  logic [1:0] read_grant;
  logic [1:0] write_grant;
  logic [1:0] stall_req;
  logic       read_timeout;
  logic       write_timeout;
  logic [0:0] timeout_id;

  int checks;
  int errors;

  xt_hb_arbiter #(
    .MASTER_NUM (2),
    .TIMEOUT    (16)
  ) dut (
    .hb_clk        (hb_clk),
    .rst_sync      (rst_sync),
    .m_read        (m_read),
    .m_write       (m_write),
    .read_finish   (read_finish),
    .write_finish  (write_finish),
    .read_grant    (read_grant),
    .write_grant   (write_grant),
    .stall_req     (stall_req),
    .read_timeout  (read_timeout),
    .write_timeout (write_timeout),
    .timeout_id    (timeout_id)
  );

  // Free-running bus clock.
  initial begin
    hb_clk = 1'b0;
    forever #5 hb_clk = ~hb_clk;
  end

  // Guard against a run that never reaches its summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock; inputs are then driven 1ns after the edge.
  task automatic step();
    @(posedge hb_clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic applyReset();
    rst_sync     = 1'b1;
    m_read       = 2'b00;
    m_write      = 2'b00;
    read_finish  = 1'b0;
    write_finish = 1'b0;
    step();
    step();
    rst_sync = 1'b0;
    settle();
  endtask

  // Reset state: no grants, no pulses, no stalls, timeout index 0.
  task automatic test_reset();
    applyReset();
    checks++;
    if (read_grant !== 2'b00) begin
      $display("[TB] FAIL reset_read_grant: got %b expected 00", read_grant); errors++;
    end
    checks++;
    if (write_grant !== 2'b00) begin
      $display("[TB] FAIL reset_write_grant: got %b expected 00", write_grant); errors++;
    end
    checks++;
    if ({read_timeout, write_timeout, timeout_id, stall_req} !== 5'b00000) begin
      $display("[TB] FAIL reset_misc: got %b expected 00000",
               {read_timeout, write_timeout, timeout_id, stall_req}); errors++;
    end
  endtask

  // M0 single read, finish three cycles after the grant.
  task automatic test_single_read();
    applyReset();
    m_read = 2'b01;
    settle();
    checks++;
    if ({read_grant, stall_req} !== 4'b0001) begin
      $display("[TB] FAIL single_latency: grant/stall got %b expected 0001", {read_grant, stall_req}); errors++;
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({read_grant, stall_req} !== 4'b0101) begin
        $display("[TB] FAIL single_busy%0d: grant/stall got %b expected 0101", c, {read_grant, stall_req}); errors++;
      end
    end
    step();
    read_finish = 1'b1;
    settle();
    checks++;
    if ({read_grant, stall_req} !== 4'b0100) begin
      $display("[TB] FAIL single_finish: grant/stall got %b expected 0100", {read_grant, stall_req}); errors++;
    end
    step();
    read_finish = 1'b0;
    m_read      = 2'b00;
    settle();
    checks++;
    if ({read_grant, stall_req} !== 4'b0000) begin
      $display("[TB] FAIL single_release: grant/stall got %b expected 0000", {read_grant, stall_req}); errors++;
    end
  endtask

  // Both masters read continuously: grants alternate 0,1,0,1,0,1 with no bubble.
  task automatic test_back_to_back();
    logic [1:0] expGrant;
    applyReset();
    m_read = 2'b11;
    step();
    for (int t = 0; t < 6; t++) begin
      expGrant = (t % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (read_grant !== expGrant) begin
        $display("[TB] FAIL rr_txn%0d: read_grant got %b expected %b", t, read_grant, expGrant); errors++;
      end
      read_finish = 1'b1;
      step();
      read_finish = 1'b0;
      settle();
    end
    m_read = 2'b00;
    step();
    checks++;
    if (read_grant !== 2'b00) begin
      $display("[TB] FAIL rr_drain: read_grant got %b expected 00", read_grant); errors++;
    end
  endtask

  // Read and write channels granted concurrently and completed separately.
  task automatic test_parallel_channels();
    applyReset();
    m_read  = 2'b01;
    m_write = 2'b10;
    step();
    checks++;
    if ({read_grant, write_grant, stall_req} !== 6'b011011) begin
      $display("[TB] FAIL par_grant: rg/wg/stall got %b expected 011011",
               {read_grant, write_grant, stall_req}); errors++;
    end
    read_finish = 1'b1;
    settle();
    checks++;
    if (stall_req !== 2'b10) begin
      $display("[TB] FAIL par_rd_finish_stall: got %b expected 10", stall_req); errors++;
    end
    step();
    read_finish = 1'b0;
    m_read      = 2'b00;
    settle();
    checks++;
    if ({read_grant, write_grant} !== 4'b0010) begin
      $display("[TB] FAIL par_after_rd: rg/wg got %b expected 0010", {read_grant, write_grant}); errors++;
    end
    write_finish = 1'b1;
    settle();
    checks++;
    if (stall_req !== 2'b00) begin
      $display("[TB] FAIL par_wr_finish_stall: got %b expected 00", stall_req); errors++;
    end
    step();
    write_finish = 1'b0;
    m_write      = 2'b00;
    settle();
    checks++;
    if (write_grant !== 2'b00) begin
      $display("[TB] FAIL par_after_wr: write_grant got %b expected 00", write_grant); errors++;
    end
  endtask

  // M1 write never finishes: timeout pulse in the 16th grant cycle.
  task automatic test_write_timeout();
    int earlyPulses;
    applyReset();
    m_write = 2'b10;
    step();
    earlyPulses = 0;
    for (int c = 0; c < 15; c++) begin
      if (write_timeout !== 1'b0) earlyPulses++;
      step();
    end
    checks++;
    if (earlyPulses !== 0) begin
      $display("[TB] FAIL to_early: %0d early pulses, expected 0", earlyPulses); errors++;
    end
    checks++;
    if ({write_timeout, timeout_id, stall_req, write_grant} !== 6'b110010) begin
      $display("[TB] FAIL to_pulse: to/id/stall/wg got %b expected 110010",
               {write_timeout, timeout_id, stall_req, write_grant}); errors++;
    end
    step();
    m_write = 2'b00;
    settle();
    checks++;
    if ({write_timeout, timeout_id, write_grant, read_timeout} !== 5'b01000) begin
      $display("[TB] FAIL to_after: to/id/wg/rto got %b expected 01000",
               {write_timeout, timeout_id, write_grant, read_timeout}); errors++;
    end
  endtask

  // Reset while M1 holds the read grant; pointer restarts at M0.
  task automatic test_reset_midbusy();
    applyReset();
    m_read = 2'b11;
    step();
    read_finish = 1'b1;
    step();
    read_finish = 1'b0;
    step();
    checks++;
    if (read_grant !== 2'b10) begin
      $display("[TB] FAIL rst_setup: read_grant got %b expected 10", read_grant); errors++;
    end
    rst_sync = 1'b1;
    step();
    rst_sync = 1'b0;
    settle();
    checks++;
    if ({read_grant, write_grant} !== 4'b0000) begin
      $display("[TB] FAIL rst_mid_drop: rg/wg got %b expected 0000", {read_grant, write_grant}); errors++;
    end
    step();
    checks++;
    if (read_grant !== 2'b01) begin
      $display("[TB] FAIL rst_ptr: read_grant got %b expected 01", read_grant); errors++;
    end
    m_read = 2'b00;
    step();
  endtask

  // M0 aborts by dropping its read; pending M1 takes over with no timeout.
  task automatic test_abort();
    applyReset();
    m_read = 2'b01;
    step();
    m_read = 2'b11;
    step();
    checks++;
    if (read_grant !== 2'b01) begin
      $display("[TB] FAIL abort_setup: read_grant got %b expected 01", read_grant); errors++;
    end
    m_read = 2'b10;
    settle();
    checks++;
    if (read_timeout !== 1'b0) begin
      $display("[TB] FAIL abort_no_timeout: read_timeout got %b expected 0", read_timeout); errors++;
    end
    step();
    checks++;
    if ({read_grant, read_timeout} !== 3'b100) begin
      $display("[TB] FAIL abort_regrant: rg/rto got %b expected 100", {read_grant, read_timeout}); errors++;
    end
    read_finish = 1'b1;
    step();
    read_finish = 1'b0;
    m_read      = 2'b00;
    settle();
    checks++;
    if (read_grant !== 2'b00) begin
      $display("[TB] FAIL abort_done: read_grant got %b expected 00", read_grant); errors++;
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    checks       = 0;
    errors       = 0;
    rst_sync     = 1'b1;
    m_read       = 2'b00;
    m_write      = 2'b00;
    read_finish  = 1'b0;
    write_finish = 1'b0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_parallel_channels();
    test_write_timeout();
    test_reset_midbusy();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/xt_hb_arbiter.md
Name: xt_hb_arbiter

Overview:
- Multi-master arbiter and sequencer for the XT_HB high-speed bus.
- Arbitrates master read and write requests independently, using round-robin on each channel, and issues one-hot read_grant/write_grant.
- Holds a grant until the addressed device signals finish. Drives per-master stall_req.
- Releases hung transactions with a timeout. Address/data muxing stays in XT_HB, driven by these grants.

Parameters:
- MASTER_NUM, 2, number of bus masters (index 0 = RISC-V core); legal range 1..8.
- TIMEOUT, 1024, bus cycles a granted transaction may wait for finish; 0 disables the timeout.

Ports:
- hb_clk  in  1  bus clock.
- rst_sync  in  1  synchronous active-high reset.
- m_read  in  MASTER_NUM  per-master read request, level, held until finish.
- m_write  in  MASTER_NUM  per-master write request, level, held until finish.
- read_finish  in  1  OR of all device read_finish; valid for the granted reader.
- write_finish  in  1  OR of all device write_finish.
- read_grant  out  MASTER_NUM  one-hot or zero, registered.
- write_grant  out  MASTER_NUM  one-hot or zero, registered.
- stall_req  out  MASTER_NUM  combinational; master must hold its request and stall.
- read_timeout  out  1  one-cycle pulse on read timeout.
- write_timeout  out  1  one-cycle pulse on write timeout.
- timeout_id  out  $clog2(MASTER_NUM) or 1  master index of the most recent timeout; read timeout wins if both fire in one cycle.

Behaviour:
- Reset and channels:
  - One clock, hb_clk. Reset is synchronous and active-high on rst_sync.
  - Reset forces all grants to 0, timeout pulses to 0, timeout_id to 0, both RR pointers to 0, both timeout counters to 0, and both channels to IDLE.
  - Read and write channels are identical, independent instances. A read grant and a write grant may be active in the same cycle, to the same or different masters.
- Per-channel FSM (IDLE, BUSY):
  - IDLE: if any request bit is set, select the first requester at or after ptr, wrapping modulo MASTER_NUM. Register its one-hot grant and go to BUSY. With no request, stay in IDLE.
  - Latency: request sampled at edge N, grant high after edge N (visible in cycle N+1).
  - BUSY, finish=1: set ptr = granted+1 (mod MASTER_NUM). Re-arbitrate in the same cycle with the finishing master's request masked.
    - Another requester exists: grant moves directly to it at the next edge; stay BUSY (no idle bubble).
    - Otherwise: grant goes to 0 and the FSM returns to IDLE.
  - BUSY, granted master drops its request without finish (abort): treat as a completion. Pointer advances and re-arbitration proceeds as above, with no timeout pulse.
  - BUSY, counter reaches TIMEOUT-1 without finish (TIMEOUT≠0): treat as a completion. Additionally pulse the channel's timeout output for one cycle, load timeout_id with the granted index, and release stall for that master in that cycle.
  - Counter: clears on every grant load; increments each BUSY cycle without finish; saturates, never wraps.
  - Finish while IDLE, or finish with no grant: ignored.
- stall_req[i] = (m_read[i] & ~(read_grant[i] & (read_finish | rd_to))) | (m_write[i] & ~(write_grant[i] & (write_finish | wr_to))).
  - A requesting master stalls every cycle until finish arrives, including the grant-latency cycle.
- Mid-transaction reset: grants drop at the reset edge. The device-side handshake is aborted by XT_HB's own reset.
- MASTER_NUM=1: pointer is constant 0 and timeout_id is tied to 0.

Decomposition:
- Add to XT_HB_Pkg: arb_state_e {ARB_IDLE, ARB_BUSY}; localparam HB_ARB_TIMEOUT; function rr_pick(req, ptr), which returns a one-hot vector.
- One sub-module, xt_hb_rr_channel, holds the FSM, pointer, counter and grant register for one channel. It is instantiated twice, for read and write.
- The top level combines stall_req and timeout_id.

Test Plan:
- Single master (M0) read; read_finish asserted 3 cycles after grant -> read_grant=01 one cycle after request, stall_req[0]=1 until the finish cycle, grant 00 the cycle after finish.
- M0 and M1 read simultaneously from reset -> M0 granted first. On finish, grant moves to M1 the next cycle with no idle cycle. With both still requesting, the next grant is M0 (alternation over 6 transactions: 0,1,0,1,0,1).
- M0 read and M1 write in the same cycle -> read_grant=01 and write_grant=10 both high in the next cycle. Each completes independently on its own finish.
- TIMEOUT=16, M1 write with no write_finish -> write_timeout pulses once after 16 grant cycles, timeout_id=1, stall_req[1]=0 in that cycle, write_grant=00 next cycle.
- Reset (rst_sync=1 for 1 cycle) while read_grant=10 is BUSY -> all grants 00 after that edge. The next requests M0+M1 grant M0 (pointer reset to 0).
- M0 granted read, M0 drops m_read without finish -> grant released the next cycle, no read_timeout, pointer advanced so a pending M1 is granted next.
